// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the
// streaming encryptor. Byte i of a 128-bit block sits at bits [127-8i -: 8].
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_t;

  // Top bit of byte i / word w of a block in FIPS byte order.
  function automatic int byte_hi(input int i);
    return 127 - 8 * i;
  endfunction

  function automatic int word_hi(input int w);
    return 127 - 32 * w;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round constant for key-schedule step rnd (1..10); zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES-128 encryption round plus the matching key-schedule step.
// The round key applied is the one derived here (rk_out); last skips MixColumns.
module aes_enc_round (
  input  logic [127:0] state_in,
  input  logic [127:0] rk_in,
  input  logic [3:0]   rnd,
  input  logic         last,
  output logic [127:0] state_out,
  output logic [127:0] rk_out
);
  import aes_pkg::*;

  logic [127:0] sb, sr, mc;
  logic [31:0]  rot_w, sub_w, temp_w;
  logic [31:0]  w0, w1, w2, w3;

  // Key schedule: SubWord(RotWord(w3)) ^ Rcon, then the xor ripple across words.
  assign rot_w = {rk_in[23:0], rk_in[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_ks
    aes_sbox u_sbox (.a(rot_w[31-8*i -: 8]), .s(sub_w[31-8*i -: 8]));
  end
  assign temp_w = sub_w ^ {rcon(rnd), 24'h000000};
  assign w0     = rk_in[127:96] ^ temp_w;
  assign w1     = rk_in[95:64]  ^ w0;
  assign w2     = rk_in[63:32]  ^ w1;
  assign w3     = rk_in[31:0]   ^ w2;
  assign rk_out = {w0, w1, w2, w3};

  // SubBytes on all sixteen state bytes.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.a(state_in[byte_hi(i) -: 8]), .s(sb[byte_hi(i) -: 8]));
  end

  // ShiftRows (row r rotates left by r) and MixColumns per column.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[byte_hi(4*c + r) -: 8] = sb[byte_hi(4*((c + r) % 4) + r) -: 8];
    end
    assign mc[word_hi(c) -: 32] = mix_col(sr[word_hi(c) -: 32]);
  end

  assign state_out = (last ? sr : mc) ^ rk_out;

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse followed by the FIPS-197 affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  import aes_pkg::*;

  logic [7:0] inv;

  // Inverse then affine transform (x ^ rotl1..4(x) ^ 0x63).
  // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    inv = gf_inv(a);
    s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes128_enc_stream.sv
// Streaming AES-128 encryptor: RPC rounds per clock, valid/ready on both sides,
// persistent key register with a per-block round-key copy taken at accept.
module aes128_enc_stream #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_we,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [15:0]  blk_cnt
);
  import aes_pkg::*;

  if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
    $error("aes128_enc_stream: RPC must be 1, 2, 5 or 10");
  end

  fsm_t         fsm;
  logic [127:0] key_q, blk_q, rk_q, key_eff, grp_st, grp_rk;
  logic [3:0]   rnd_q;
  logic         accept, last_grp;

  assign in_ready = (fsm == S_IDLE) || ((fsm == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (fsm != S_IDLE);
  // A key written in the accept cycle is used by that block.
  assign key_eff  = key_we ? key_in : key_q;

  // RPC rounds chained combinationally; stage j handles round rnd_q + j.
  for (genvar j = 0; j < RPC; j++) begin : g_rnd
    logic [127:0] st_i, rk_i, st_o, rk_o;
    logic [3:0]   rnd_j;
    if (j == 0) begin : g_head
      assign st_i = blk_q;
      assign rk_i = rk_q;
    end else begin : g_link
      assign st_i = g_rnd[j-1].st_o;
      assign rk_i = g_rnd[j-1].rk_o;
    end
    assign rnd_j = rnd_q + 4'(j);
    aes_enc_round u_round (
      .state_in (st_i),
      .rk_in    (rk_i),
      .rnd      (rnd_j),
      .last     (rnd_j == 4'(NR)),
      .state_out(st_o),
      .rk_out   (rk_o)
    );
  end

  assign grp_st   = g_rnd[RPC-1].st_o;
  assign grp_rk   = g_rnd[RPC-1].rk_o;
  // RPC divides NR, so groups are aligned and the final group ends exactly on NR.
  assign last_grp = (rnd_q + 4'(RPC - 1)) == 4'(NR);

  // Control FSM, key register and registered handshake outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm       <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      blk_cnt   <= '0;
      key_q     <= '0;
    end else begin
      if (key_we) key_q <= key_in;
      case (fsm)
        S_IDLE: if (accept) fsm <= S_RUN;
        S_RUN: begin
          if (last_grp) begin
            out_data  <= grp_st;
            out_valid <= 1'b1;
            fsm       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            blk_cnt   <= blk_cnt + 16'd1;
            out_valid <= 1'b0;
            fsm       <= in_valid ? S_RUN : S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // Working state, in-flight round key and round index.
  // NOTE: these datapath registers are deliberately not reset; accept always loads them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      blk_q <= in_data ^ key_eff;
      rk_q  <= key_eff;
      rnd_q <= 4'd1;
    end else if (fsm == S_RUN) begin
      blk_q <= grp_st;
      rk_q  <= grp_rk;
      rnd_q <= rnd_q + 4'(RPC);
    end
  end

endmodule
